// File: rtl/sysbus_pkg.sv
// Shared SysBus definitions: bus width, wait-state limit and responder FSM states.
package sysbus_pkg;

    localparam int SYSBUS_W = 16;
    localparam int WAIT_MAX = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DATA = 2'd3
    } resp_state_t;

endpackage

// File: rtl/sysbus_spram.sv
// Single-port synchronous RAM, 2**AW words of SysBus width, registered read, no reset.
module sysbus_spram
    import sysbus_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic                Clock,
    input  logic                We,
    input  logic [AW-1:0]       Addr,
    input  logic [SYSBUS_W-1:0] WData,
    output logic [SYSBUS_W-1:0] RData
);

    logic [SYSBUS_W-1:0] mem [2**AW];

    always_ff @(posedge Clock) begin
        if (We) begin
            mem[Addr] <= WData;
        end
        RData <= mem[Addr];
    end

endmodule

// File: rtl/sysbus_mem_responder.sv
// SysBus memory responder: address decode, programmable wait states, then a
// one-cycle registered Ready (read data driven with BusOe) or Err strobe.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int          AW          = 8,
    parameter logic [15:0] BASE        = 16'h0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [SYSBUS_W-1:0] BusIn,
    input  logic                Ale,
    input  logic                Rd,
    input  logic                Wr,
    output logic [SYSBUS_W-1:0] BusOut,
    output logic                BusOe,
    output logic                Ready,
    output logic                Err
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    if (WAIT_STATES < 0 || WAIT_STATES > WAIT_MAX) begin : g_wait_range
        $error("WAIT_STATES out of range");
    end

    resp_state_t         state, state_n;
    logic [AW-1:0]       addr, addr_n;
    logic [3:0]          waitcnt, waitcnt_n;
    logic                dir_wr, dir_wr_n;
    logic                err_n;
    logic                hit;
    logic                ram_we;
    logic [SYSBUS_W-1:0] ram_rdata;

    assign hit = (BusIn[SYSBUS_W-1:AW] == BASE[SYSBUS_W-1:AW]);

    // Outputs are registered off DATA, so the Ready cycle follows DATA; the
    // write commits at the edge ending that cycle while the core still holds data.
    assign ram_we = Ready && dir_wr;

    sysbus_spram #(.AW(AW)) u_ram (
        .Clock (Clock),
        .We    (ram_we),
        .Addr  (addr),
        .WData (BusIn),
        .RData (ram_rdata)
    );

    always_comb begin
        state_n   = state;
        addr_n    = addr;
        waitcnt_n = waitcnt;
        dir_wr_n  = dir_wr;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                if (Ale && hit) begin
                    addr_n  = BusIn[AW-1:0];
                    state_n = ADDR;
                end
            end
            ADDR: begin
                if (Ale) begin
                    if (hit) begin
                        addr_n = BusIn[AW-1:0];
                    end else begin
                        state_n = IDLE;
                    end
                end else if (Rd && Wr) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (Rd || Wr) begin
                    dir_wr_n = Wr;
                    if (WAIT_STATES == 0) begin
                        state_n = DATA;
                    end else begin
                        state_n   = WAIT;
                        waitcnt_n = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (dir_wr ? !Wr : !Rd) begin
                    state_n = IDLE;
                end else if (waitcnt == 4'd0) begin
                    state_n = DATA;
                end else begin
                    waitcnt_n = waitcnt - 4'd1;
                end
            end
            DATA: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            addr    <= '0;
            waitcnt <= '0;
            dir_wr  <= 1'b0;
            BusOut  <= '0;
            BusOe   <= 1'b0;
            Ready   <= 1'b0;
            Err     <= 1'b0;
        end else begin
            state   <= state_n;
            addr    <= addr_n;
            waitcnt <= waitcnt_n;
            dir_wr  <= dir_wr_n;
            Err     <= err_n;
            Ready   <= (state == DATA);
            BusOe   <= (state == DATA) && !dir_wr;
            BusOut  <= ((state == DATA) && !dir_wr) ? ram_rdata : '0;
        end
    end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: three instances (1, 3 and 0 wait
// states), directed accesses push expected responses, a monitor pops and compares.
module tb_sysbus_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bus_in  [3];
    logic [15:0] bus_out [3];
    logic [2:0]  ale = '0;
    logic [2:0]  rd  = '0;
    logic [2:0]  wr  = '0;
    logic [2:0]  oe;
    logic [2:0]  rdy;
    logic [2:0]  err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          k;
        int          kind;   // 0 read, 1 write, 2 protocol error
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [15:0] refm [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sysbus_mem_responder #(.AW(8), .BASE(16'h0000), .WAIT_STATES(1)) u0 (
        .Clock(clk), .Reset(rst), .BusIn(bus_in[0]), .Ale(ale[0]), .Rd(rd[0]), .Wr(wr[0]),
        .BusOut(bus_out[0]), .BusOe(oe[0]), .Ready(rdy[0]), .Err(err[0]));
    sysbus_mem_responder #(.AW(8), .BASE(16'h0000), .WAIT_STATES(3)) u1 (
        .Clock(clk), .Reset(rst), .BusIn(bus_in[1]), .Ale(ale[1]), .Rd(rd[1]), .Wr(wr[1]),
        .BusOut(bus_out[1]), .BusOe(oe[1]), .Ready(rdy[1]), .Err(err[1]));
    sysbus_mem_responder #(.AW(8), .BASE(16'h0000), .WAIT_STATES(0)) u2 (
        .Clock(clk), .Reset(rst), .BusIn(bus_in[2]), .Ale(ale[2]), .Rd(rd[2]), .Wr(wr[2]),
        .BusOut(bus_out[2]), .BusOe(oe[2]), .Ready(rdy[2]), .Err(err[2]));

    function automatic int ws_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic exp_t mk(input int k, input int kind, input logic [15:0] d, input int due);
        exp_t e;
        e.k = k; e.kind = kind; e.data = d; e.due = due;
        return e;
    endfunction

    // Monitor: every cycle with any response output active consumes one expectation.
    initial begin : monitor
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (rdy[k] || oe[k] || err[k]) begin
                    tests++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_resp inst=%0d cyc=%0d ready=%b oe=%b err=%b data=%h required no response",
                                 k, cyc, rdy[k], oe[k], err[k], bus_out[k]);
                    end else begin
                        e  = q.pop_front();
                        ok = (e.k == k) && (e.due == cyc);
                        case (e.kind)
                            0:       ok = ok && rdy[k] && oe[k] && !err[k] && (bus_out[k] == e.data);
                            1:       ok = ok && rdy[k] && !oe[k] && !err[k];
                            default: ok = ok && err[k] && !rdy[k] && !oe[k];
                        endcase
                        if (!ok) begin
                            fails++;
                            $display("FAIL resp inst=%0d cyc=%0d ready=%b oe=%b err=%b data=%h required inst=%0d kind=%0d cyc=%0d data=%h",
                                     k, cyc, rdy[k], oe[k], err[k], bus_out[k], e.k, e.kind, e.due, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_ready(input int k);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rdy[k]) return;
        end
        tests++;
        fails++;
        $display("FAIL ready_timeout inst=%0d got no Ready in 40 cycles required Ready", k);
    endtask

    // kind 0 = read expecting d, kind 1 = write of d
    task automatic access(input int k, input int kind, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        ale[k] = 1'b1;
        bus_in[k] = a;
        q.push_back(mk(k, kind, d, cyc + 3 + ws_of(k)));
        @(negedge clk);
        ale[k] = 1'b0;
        if (kind == 1) begin
            wr[k] = 1'b1;
            bus_in[k] = d;
        end else begin
            rd[k] = 1'b1;
            bus_in[k] = '0;
        end
        wait_ready(k);
        @(negedge clk);
        rd[k] = 1'b0;
        wr[k] = 1'b0;
        bus_in[k] = '0;
    endtask

    task automatic quiet_window(input int k, input int n, input string name);
        int hits = 0;
        repeat (n) begin
            @(negedge clk);
            if (rdy[k] || oe[k] || err[k]) hits++;
        end
        tests++;
        if (hits != 0) begin
            fails++;
            $display("FAIL %s inst=%0d active_cycles=%0d required 0", name, k, hits);
        end
    endtask

    initial begin : stim
        logic [15:0] d;
        int          a;
        for (int k = 0; k < 3; k++) bus_in[k] = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (rdy[k] || oe[k] || err[k] || bus_out[k] != 16'h0000) begin
                fails++;
                $display("FAIL reset_state inst=%0d ready=%b oe=%b err=%b data=%h required 0 0 0 0000",
                         k, rdy[k], oe[k], err[k], bus_out[k]);
            end
        end

        // one wait state: read latency, write then read back, neighbours untouched
        access(0, 1, 16'h0010, 16'hBEEF);
        access(0, 0, 16'h0010, 16'hBEEF);
        access(0, 1, 16'h0021, 16'h1111);
        access(0, 1, 16'h0023, 16'h3333);
        access(0, 1, 16'h0022, 16'h1234);
        access(0, 0, 16'h0022, 16'h1234);
        access(0, 0, 16'h0021, 16'h1111);
        access(0, 0, 16'h0023, 16'h3333);
        access(0, 0, 16'h0010, 16'hBEEF);

        // decode miss: address above the 256-word window
        @(negedge clk);
        ale[0] = 1'b1;
        bus_in[0] = 16'h0110;
        @(negedge clk);
        ale[0] = 1'b0;
        bus_in[0] = '0;
        rd[0] = 1'b1;
        quiet_window(0, 20, "decode_miss");
        rd[0] = 1'b0;
        access(0, 0, 16'h0010, 16'hBEEF);

        // Rd and Wr together in ADDR
        @(negedge clk);
        ale[0] = 1'b1;
        bus_in[0] = 16'h0021;
        q.push_back(mk(0, 2, 16'h0000, cyc + 2));
        @(negedge clk);
        ale[0] = 1'b0;
        bus_in[0] = 16'hFFFF;
        rd[0] = 1'b1;
        wr[0] = 1'b1;
        @(negedge clk);
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        bus_in[0] = '0;
        repeat (2) @(negedge clk);
        access(0, 0, 16'h0021, 16'h1111);
        access(0, 0, 16'h0022, 16'h1234);

        // reset during the write data phase must not commit
        access(0, 1, 16'h0040, 16'h5555);
        @(negedge clk);
        ale[0] = 1'b1;
        bus_in[0] = 16'h0040;
        q.push_back(mk(0, 1, 16'h0000, cyc + 4));
        @(negedge clk);
        ale[0] = 1'b0;
        wr[0] = 1'b1;
        bus_in[0] = 16'hDEAD;
        wait_ready(0);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (rdy[0] || oe[0]) begin
            fails++;
            $display("FAIL reset_async_drop ready=%b oe=%b required 0 0", rdy[0], oe[0]);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        wr[0] = 1'b0;
        bus_in[0] = '0;
        access(0, 0, 16'h0040, 16'h5555);

        // three wait states: aborted read and write
        access(1, 1, 16'h0030, 16'h0F0F);
        @(negedge clk);
        ale[1] = 1'b1;
        bus_in[1] = 16'h0030;
        @(negedge clk);
        ale[1] = 1'b0;
        bus_in[1] = '0;
        rd[1] = 1'b1;
        @(negedge clk);
        rd[1] = 1'b0;
        quiet_window(1, 15, "abort_read");
        @(negedge clk);
        ale[1] = 1'b1;
        bus_in[1] = 16'h0030;
        @(negedge clk);
        ale[1] = 1'b0;
        bus_in[1] = 16'hAAAA;
        wr[1] = 1'b1;
        @(negedge clk);
        wr[1] = 1'b0;
        bus_in[1] = '0;
        quiet_window(1, 15, "abort_write");
        access(1, 0, 16'h0030, 16'h0F0F);

        // zero wait states against a reference model
        for (int i = 0; i < 256; i++) begin
            d = 16'($urandom);
            refm[i] = d;
            access(2, 1, 16'(i), d);
        end
        for (int i = 0; i < 256; i++) begin
            a = int'($urandom_range(0, 255));
            access(2, 0, 16'(a), refm[a]);
        end

        repeat (5) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL pending_expectations left=%0d required 0", q.size());
        end
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
